// File: rtl/mmio_bus_router.sv
// mmio_bus_router
// ---------------
// Data-side address router between the core's memory interface and a set of
// memory-mapped targets (BRAM, UART, timer, software-interrupt register, ...).
// Each request is decoded against per-slave [base, limit) windows. Writes are
// posted. Reads are tracked in a small in-order FIFO so that responses go back
// in issue order even when slaves have different latencies. Accesses that hit
// no window are reported as faults instead of being steered to a default slave.
//
// Ports
//   clock, reset        : system clock, synchronous active-high reset
//   req_read/req_write  : request strobes from the memory interface
//   req_byte_en/address/data : request payload
//   req_ready           : router can take a request this cycle
//   resp_valid/data/address/fault : registered in-order read response
//   write_fault         : pulse, an unmapped write was accepted last cycle
//   protocol_error      : sticky, a slave returned data nobody was waiting for
//   slv_read/slv_write  : one-hot per-slave strobes
//   slv_byte_en/address/wdata : request payload broadcast to all slaves
//   slv_rdata/slv_rvalid : per-slave read return paths
module mmio_bus_router #(
  parameter int NUM_SLAVES      = 4,
  parameter int DATA_WIDTH      = 64,
  parameter int ADDRESS_BITS    = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [NUM_SLAVES*ADDRESS_BITS-1:0] SLAVE_BASE =
    {64'hE0000, 64'hD0000, 64'hC0000, 64'h0},
  parameter logic [NUM_SLAVES*ADDRESS_BITS-1:0] SLAVE_LIMIT =
    {64'hE0008, 64'hD0011, 64'hC0028, 64'h4000}
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             req_read,
  input  logic                             req_write,
  input  logic [DATA_WIDTH/8-1:0]          req_byte_en,
  input  logic [ADDRESS_BITS-1:0]          req_address,
  input  logic [DATA_WIDTH-1:0]            req_data,
  output logic                             req_ready,
  output logic                             resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_data,
  output logic [ADDRESS_BITS-1:0]          resp_address,
  output logic                             resp_fault,
  output logic                             write_fault,
  output logic                             protocol_error,
  output logic [NUM_SLAVES-1:0]            slv_read,
  output logic [NUM_SLAVES-1:0]            slv_write,
  output logic [DATA_WIDTH/8-1:0]          slv_byte_en,
  output logic [ADDRESS_BITS-1:0]          slv_address,
  output logic [DATA_WIDTH-1:0]            slv_wdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]            slv_rvalid
);

  localparam int SID_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  // Address decode
  logic             decHit;
  logic [SID_W-1:0] decSid;
  logic [NUM_SLAVES-1:0] decOneHot;

  // Read tracker FIFO
  logic                    trkMapped_q [MAX_OUTSTANDING];
  logic [SID_W-1:0]        trkSid_q    [MAX_OUTSTANDING];
  logic [ADDRESS_BITS-1:0] trkAddr_q   [MAX_OUTSTANDING];
  logic [PTR_W-1:0]        wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]        rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    push, pop;
  logic                    headMapped;
  logic [SID_W-1:0]        headSid;
  logic [ADDRESS_BITS-1:0] headAddr;
  logic [NUM_SLAVES-1:0]   slvPending;

  // Per-slave hold buffers
  logic [NUM_SLAVES-1:0]   bufFull_q, bufFull_d;
  logic [DATA_WIDTH-1:0]   bufData_q [NUM_SLAVES];
  logic [DATA_WIDTH-1:0]   bufData_d [NUM_SLAVES];
  logic [NUM_SLAVES-1:0]   consumed;
  logic [NUM_SLAVES-1:0]   bufClr;
  logic                    protoErr_q, protoErr_d;

  // Response registers
  logic                    respValid_q, respValid_d;
  logic                    respFault_q, respFault_d;
  logic [DATA_WIDTH-1:0]   respData_q, respData_d;
  logic [ADDRESS_BITS-1:0] respAddr_q, respAddr_d;
  logic                    writeFault_q, writeFault_d;

  // Window decode. Scanning from the top index down lets the lowest matching
  // slave overwrite any higher one, which gives lowest-index-wins on overlap.
  always_comb begin
    decHit = 1'b0;
    decSid = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((req_address >= SLAVE_BASE[i*ADDRESS_BITS +: ADDRESS_BITS]) &&
          (req_address <  SLAVE_LIMIT[i*ADDRESS_BITS +: ADDRESS_BITS])) begin
        decHit = 1'b1;
        decSid = SID_W'(i);
      end
    end
    decOneHot = '0;
    if (decHit) decOneHot[decSid] = 1'b1;
  end

  // Strobes only fire when the request is actually accepted, so a stalled
  // read never reaches a slave twice.
  assign req_ready   = (count_q < CNT_W'(MAX_OUTSTANDING));
  assign slv_read    = (req_read  && req_ready) ? decOneHot : '0;
  assign slv_write   = (req_write && req_ready) ? decOneHot : '0;
  assign slv_byte_en = req_byte_en;
  assign slv_address = req_address;
  assign slv_wdata   = req_data;
  assign push        = req_read && req_ready;

  assign headMapped = trkMapped_q[rdPtr_q];
  assign headSid    = trkSid_q[rdPtr_q];
  assign headAddr   = trkAddr_q[rdPtr_q];

  // Which slaves currently owe us data: any live tracker slot that points at
  // them. A slot is live when its distance from the read pointer is below
  // the occupancy count.
  always_comb begin
    logic [PTR_W-1:0] offs;
    slvPending = '0;
    for (int k = 0; k < MAX_OUTSTANDING; k++) begin
      offs = PTR_W'(k) - rdPtr_q;
      if (({1'b0, offs} < count_q) && trkMapped_q[k]) slvPending[trkSid_q[k]] = 1'b1;
    end
  end

  // Head-of-line response selection. Buffered data takes precedence over the
  // live return path; faults retire immediately. At most one pop per cycle.
  always_comb begin
    pop         = 1'b0;
    consumed    = '0;
    bufClr      = '0;
    respValid_d = 1'b0;
    respFault_d = 1'b0;
    respData_d  = '0;
    respAddr_d  = '0;
    if (count_q != '0) begin
      if (!headMapped) begin
        pop         = 1'b1;
        respValid_d = 1'b1;
        respFault_d = 1'b1;
        respAddr_d  = headAddr;
      end else if (bufFull_q[headSid]) begin
        pop             = 1'b1;
        respValid_d     = 1'b1;
        respData_d      = bufData_q[headSid];
        respAddr_d      = headAddr;
        bufClr[headSid] = 1'b1;
      end else if (slv_rvalid[headSid]) begin
        pop               = 1'b1;
        respValid_d       = 1'b1;
        respData_d        = slv_rdata[int'(headSid)*DATA_WIDTH +: DATA_WIDTH];
        respAddr_d        = headAddr;
        consumed[headSid] = 1'b1;
      end
    end
  end

  // Hold-buffer capture. Returned data that the head cannot take right now is
  // parked; data arriving on a full buffer or for a slave with nothing
  // outstanding is dropped and flagged.
  always_comb begin
    bufFull_d  = bufFull_q;
    bufData_d  = bufData_q;
    protoErr_d = protoErr_q;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (bufClr[i]) bufFull_d[i] = 1'b0;
      if (slv_rvalid[i] && !consumed[i]) begin
        if (bufFull_q[i] || !slvPending[i]) begin
          protoErr_d = 1'b1;
        end else begin
          bufFull_d[i] = 1'b1;
          bufData_d[i] = slv_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Tracker pointer and occupancy update; pointers wrap naturally because the
  // depth is a power of two.
  always_comb begin
    wrPtr_d      = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d      = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    count_d      = count_q;
    if (push && !pop) count_d = count_q + CNT_W'(1);
    if (!push && pop) count_d = count_q - CNT_W'(1);
    writeFault_d = req_write && req_ready && !decHit;
  end

  // Control state with synchronous reset; anything in flight is forgotten.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      bufFull_q    <= '0;
      protoErr_q   <= 1'b0;
      respValid_q  <= 1'b0;
      respFault_q  <= 1'b0;
      respData_q   <= '0;
      respAddr_q   <= '0;
      writeFault_q <= 1'b0;
    end else begin
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      bufFull_q    <= bufFull_d;
      protoErr_q   <= protoErr_d;
      respValid_q  <= respValid_d;
      respFault_q  <= respFault_d;
      respData_q   <= respData_d;
      respAddr_q   <= respAddr_d;
      writeFault_q <= writeFault_d;
    end
  end

  // Payload storage needs no reset: validity is carried by count_q/bufFull_q.
  always_ff @(posedge clock) begin
    if (push) begin
      trkMapped_q[wrPtr_q] <= decHit;
      trkSid_q[wrPtr_q]    <= decSid;
      trkAddr_q[wrPtr_q]   <= req_address;
    end
    bufData_q <= bufData_d;
  end

  assign resp_valid     = respValid_q;
  assign resp_fault     = respFault_q;
  assign resp_data      = respData_q;
  assign resp_address   = respAddr_q;
  assign write_fault    = writeFault_q;
  assign protocol_error = protoErr_q;

endmodule

// File: tb/tb_mmio_bus_router.sv
// Directed testbench for mmio_bus_router. Inputs change 1ns after the rising
// edge; combinational outputs are checked 1ns later and registered outputs
// right after the edge that updates them.
module tb_mmio_bus_router;

  logic         clock = 1'b0;
  logic         reset;
  logic         reqRead, reqWrite;
  logic [7:0]   reqByteEn;
  logic [63:0]  reqAddress, reqData;
  logic         reqReady, respValid, respFault, writeFault, protocolError;
  logic [63:0]  respData, respAddress;
  logic [3:0]   slvRead, slvWrite;
  logic [7:0]   slvByteEn;
  logic [63:0]  slvAddress, slvWdata;
  logic [255:0] slvRdata;
  logic [3:0]   slvRvalid;

  // Second instance with overlapping windows to exercise decode priority
  logic         reqRead2;
  logic [63:0]  reqAddress2;
  logic         reqReady2, respValid2, respFault2, writeFault2, protocolError2;
  logic [63:0]  respData2, respAddress2, slvAddress2, slvWdata2;
  logic [1:0]   slvRead2, slvWrite2;
  logic [7:0]   slvByteEn2;
  logic [127:0] slvRdata2;
  logic [1:0]   slvRvalid2;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] expAddrQ[$];
  logic [63:0] expAddr;

  always #5 clock = ~clock;

  mmio_bus_router dut (
    .clock(clock), .reset(reset),
    .req_read(reqRead), .req_write(reqWrite), .req_byte_en(reqByteEn),
    .req_address(reqAddress), .req_data(reqData), .req_ready(reqReady),
    .resp_valid(respValid), .resp_data(respData), .resp_address(respAddress),
    .resp_fault(respFault), .write_fault(writeFault), .protocol_error(protocolError),
    .slv_read(slvRead), .slv_write(slvWrite), .slv_byte_en(slvByteEn),
    .slv_address(slvAddress), .slv_wdata(slvWdata),
    .slv_rdata(slvRdata), .slv_rvalid(slvRvalid)
  );

  mmio_bus_router #(
    .NUM_SLAVES(2),
    .SLAVE_BASE({64'h0, 64'h0}),
    .SLAVE_LIMIT({64'h100, 64'h4000})
  ) dut2 (
    .clock(clock), .reset(reset),
    .req_read(reqRead2), .req_write(1'b0), .req_byte_en(8'hFF),
    .req_address(reqAddress2), .req_data(64'h0), .req_ready(reqReady2),
    .resp_valid(respValid2), .resp_data(respData2), .resp_address(respAddress2),
    .resp_fault(respFault2), .write_fault(writeFault2), .protocol_error(protocolError2),
    .slv_read(slvRead2), .slv_write(slvWrite2), .slv_byte_en(slvByteEn2),
    .slv_address(slvAddress2), .slv_wdata(slvWdata2),
    .slv_rdata(slvRdata2), .slv_rvalid(slvRvalid2)
  );

  // Advance to 1ns past the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [63:0] addr, input logic [63:0] data);
    reqRead    = rd;
    reqWrite   = wr;
    reqAddress = addr;
    reqData    = data;
    reqByteEn  = 8'hA5;
  endtask

  // Drive one slave's return path (slot < 0 means all idle)
  task automatic setRvalid(input int slot, input logic [63:0] data);
    slvRvalid = '0;
    slvRdata  = '0;
    if (slot >= 0) begin
      slvRvalid[slot]          = 1'b1;
      slvRdata[slot*64 +: 64]  = data;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    reqRead2    = 1'b0;
    reqAddress2 = '0;
    slvRdata2   = '0;
    slvRvalid2  = '0;
    applyStimulus(1'b0, 1'b0, 64'h0, 64'h0);
    setRvalid(-1, 64'h0);
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    $display("[TB] reset state");
    checkOutput("rst_ready", reqReady, 1);
    checkOutput("rst_resp_valid", respValid, 0);
    checkOutput("rst_resp_data", respData, 0);
    checkOutput("rst_resp_address", respAddress, 0);
    checkOutput("rst_write_fault", writeFault, 0);
    checkOutput("rst_protocol_error", protocolError, 0);

    // 1: single BRAM read, latency 1
    $display("[TB] single BRAM read");
    applyStimulus(1'b1, 1'b0, 64'h100, 64'h0);
    #1;
    checkOutput("t1_slv_read", slvRead, 4'b0001);
    checkOutput("t1_slv_address", slvAddress, 64'h100);
    checkOutput("t1_slv_byte_en", slvByteEn, 8'hA5);
    tick();
    applyStimulus(1'b0, 1'b0, 64'h0, 64'h0);
    setRvalid(0, 64'hDEADBEEF);
    checkOutput("t1_no_early_resp", respValid, 0);
    tick();
    setRvalid(-1, 64'h0);
    checkOutput("t1_resp_valid", respValid, 1);
    checkOutput("t1_resp_data", respData, 64'hDEADBEEF);
    checkOutput("t1_resp_address", respAddress, 64'h100);
    checkOutput("t1_resp_fault", respFault, 0);
    tick();
    checkOutput("t1_resp_pulse", respValid, 0);

    // 2: timer (slow) then BRAM (fast); BRAM data waits in its hold buffer
    $display("[TB] out-of-order return, in-order response");
    applyStimulus(1'b1, 1'b0, 64'hD0000, 64'h0);
    #1;
    checkOutput("t2_slv_read_timer", slvRead, 4'b0100);
    tick();
    applyStimulus(1'b1, 1'b0, 64'h8, 64'h0);
    #1;
    checkOutput("t2_slv_read_bram", slvRead, 4'b0001);
    tick();
    applyStimulus(1'b0, 1'b0, 64'h0, 64'h0);
    setRvalid(0, 64'h11112222);
    checkOutput("t2_wait0", respValid, 0);
    tick();
    setRvalid(2, 64'h33334444);
    checkOutput("t2_wait1", respValid, 0);
    tick();
    setRvalid(-1, 64'h0);
    checkOutput("t2_first_valid", respValid, 1);
    checkOutput("t2_first_data", respData, 64'h33334444);
    checkOutput("t2_first_address", respAddress, 64'hD0000);
    tick();
    checkOutput("t2_second_valid", respValid, 1);
    checkOutput("t2_second_data", respData, 64'h11112222);
    checkOutput("t2_second_address", respAddress, 64'h8);
    checkOutput("t2_no_proto_err", protocolError, 0);
    tick();
    checkOutput("t2_idle", respValid, 0);

    // 3: unmapped read and write, then a mapped write
    $display("[TB] unmapped accesses");
    applyStimulus(1'b1, 1'b0, 64'hF00000, 64'h0);
    #1;
    checkOutput("t3_no_slv_read", slvRead, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 64'h0, 64'h0);
    checkOutput("t3_fault_not_yet", respValid, 0);
    tick();
    checkOutput("t3_fault_valid", respValid, 1);
    checkOutput("t3_fault_flag", respFault, 1);
    checkOutput("t3_fault_data", respData, 0);
    checkOutput("t3_fault_address", respAddress, 64'hF00000);
    applyStimulus(1'b0, 1'b1, 64'hF00000, 64'h1234);
    #1;
    checkOutput("t3_no_slv_write", slvWrite, 0);
    tick();
    applyStimulus(1'b0, 1'b1, 64'hC0010, 64'hCAFE);
    #1;
    checkOutput("t3_write_fault", writeFault, 1);
    checkOutput("t3_uart_write", slvWrite, 4'b0010);
    checkOutput("t3_wdata", slvWdata, 64'hCAFE);
    tick();
    applyStimulus(1'b0, 1'b0, 64'h0, 64'h0);
    checkOutput("t3_no_write_fault", writeFault, 0);
    checkOutput("t3_no_write_resp", respValid, 0);

    // 4: fill tracker against a stalled slave, then stream with wrap-around
    $display("[TB] tracker full and wrap-around");
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b1, 1'b0, 64'hE0000 + 64'(j), 64'h0);
      expAddrQ.push_back(64'hE0000 + 64'(j));
      #1;
      checkOutput("t4_ready_fill", reqReady, 1);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 64'hE0004, 64'h0);
    setRvalid(3, 64'hA000);
    #1;
    checkOutput("t4_ready_full", reqReady, 0);
    checkOutput("t4_gated_read", slvRead, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 64'h0, 64'h0);
    setRvalid(-1, 64'h0);
    expAddr = expAddrQ.pop_front();
    checkOutput("t4_ready_again", reqReady, 1);
    checkOutput("t4_drain_valid", respValid, 1);
    checkOutput("t4_drain_address", respAddress, expAddr);
    checkOutput("t4_drain_data", respData, 64'hA000);
    for (int j = 0; j < 10; j++) begin
      applyStimulus(1'b1, 1'b0, 64'hE0000 + 64'(j % 8), 64'h0);
      expAddrQ.push_back(64'hE0000 + 64'(j % 8));
      setRvalid(3, 64'hB000 + 64'(j));
      #1;
      checkOutput("t4_stream_ready", reqReady, 1);
      tick();
      expAddr = expAddrQ.pop_front();
      checkOutput("t4_stream_valid", respValid, 1);
      checkOutput("t4_stream_address", respAddress, expAddr);
      checkOutput("t4_stream_data", respData, 64'hB000 + 64'(j));
    end
    applyStimulus(1'b0, 1'b0, 64'h0, 64'h0);
    for (int k = 0; k < 3; k++) begin
      setRvalid(3, 64'hC000 + 64'(k));
      tick();
      expAddr = expAddrQ.pop_front();
      checkOutput("t4_tail_valid", respValid, 1);
      checkOutput("t4_tail_address", respAddress, expAddr);
    end
    setRvalid(-1, 64'h0);
    tick();
    checkOutput("t4_empty_idle", respValid, 0);
    checkOutput("t4_no_proto_err", protocolError, 0);

    // 5: reset with reads in flight, late data is a protocol error
    $display("[TB] reset with reads outstanding");
    applyStimulus(1'b1, 1'b0, 64'hE0000, 64'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 64'hE0001, 64'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 64'h0, 64'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t5_ready_after_reset", reqReady, 1);
    checkOutput("t5_no_resp_after_reset", respValid, 0);
    setRvalid(3, 64'h5555);
    tick();
    setRvalid(-1, 64'h0);
    checkOutput("t5_proto_err", protocolError, 1);
    checkOutput("t5_no_resp", respValid, 0);
    tick();
    checkOutput("t5_proto_err_sticky", protocolError, 1);
    checkOutput("t5_still_no_resp", respValid, 0);
    checkOutput("t5_ready", reqReady, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t5_proto_err_cleared", protocolError, 0);

    // 6: overlapping windows, lowest index wins
    $display("[TB] overlapping windows");
    reqRead2    = 1'b1;
    reqAddress2 = 64'h80;
    #1;
    checkOutput("t6_overlap_low_wins", slvRead2, 2'b01);
    reqAddress2 = 64'h2000;
    #1;
    checkOutput("t6_bram_only", slvRead2, 2'b01);
    reqAddress2 = 64'h5000;
    #1;
    checkOutput("t6_unmapped", slvRead2, 2'b00);
    reqRead2 = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
